limn2600_bus_ctrl: RTL and testbench

Single-master memory bus controller between the Limn2600 CPU load/store/fetch port and the three memory slaves (ROM, RAM, NVRAM). It accepts one word request at a time and decodes the address to a bank. It strobes the selected slave's `ce` with `we`/`oe` for exactly one cycle, waits for that slave's `rdy`, and returns `cpu_rdata` with a one-cycle `cpu_ack`. Unmapped addresses and ROM writes, and slave timeouts when that feature is enabled, return a one-cycle `cpu_err` instead.

---
 rtl/limn2600_bus_ctrl_if.sv | 51 +++++
 rtl/limn2600_bus_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_limn2600_bus_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/limn2600_bus_ctrl_if.sv
// Limn2600 memory bus bundle: CPU request/response side plus the shared
// slave command bus and per-slave enable/ready/data lines.
// master: the bus controller's view. slave: the CPU + memory environment's view.
interface limn2600_bus_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  // CPU side
  logic                  cpu_req;
  logic                  cpu_we;
  logic [31:0]           cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_busy;
  logic                  cpu_ack;
  logic                  cpu_err;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  // Shared slave command bus
  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_we;
  logic                  mem_oe;

  // Per-slave lines
  logic                  rom_ce;
  logic                  ram_ce;
  logic                  nvram_ce;
  logic                  rom_rdy;
  logic                  ram_rdy;
  logic                  nvram_rdy;
  logic [DATA_WIDTH-1:0] rom_data_out;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic [DATA_WIDTH-1:0] nvram_data_out;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_busy, cpu_ack, cpu_err, cpu_rdata,
    output mem_addr, mem_data_in, mem_we, mem_oe,
    output rom_ce, ram_ce, nvram_ce,
    input  rom_rdy, ram_rdy, nvram_rdy,
    input  rom_data_out, ram_data_out, nvram_data_out
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_busy, cpu_ack, cpu_err, cpu_rdata,
    input  mem_addr, mem_data_in, mem_we, mem_oe,
    input  rom_ce, ram_ce, nvram_ce,
    output rom_rdy, ram_rdy, nvram_rdy,
    output rom_data_out, ram_data_out, nvram_data_out
  );
endinterface

// File: rtl/limn2600_bus_ctrl.sv
// Limn2600 single-master memory bus controller.
// One word request at a time: decode to ROM/RAM/NVRAM, strobe the slave's ce
// for one cycle, wait for its rdy, answer with a one-cycle ack (or err for
// unmapped addresses and ROM writes).
// Optional feature: define LIMN2600_BUS_TIMEOUT_EN to bound the wait for rdy
// to TIMEOUT_CYCLES, after which the request ends in a bus error.
module limn2600_bus_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                 clk,
  input logic                 rst,
  limn2600_bus_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StResp,
    StErr
  } state_e;

  typedef enum logic [1:0] {
    BankNone,
    BankRam,
    BankRom,
    BankNvram
  } bank_e;

  state_e                state_q, state_d;
  bank_e                 bank_q, bank_d;
  bank_e                 req_bank;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  sel_rdy;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  issue;

`ifdef LIMN2600_BUS_TIMEOUT_EN
  localparam int unsigned         CntWidth   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntWidth-1:0] TimeoutCnt = CntWidth'(TIMEOUT_CYCLES);

  logic [CntWidth-1:0] cnt_q, cnt_d;
`else
  // Without the timeout feature the limit has no effect on the logic.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  // Address decode of the incoming request on the upper half-word.
  always_comb begin
    unique case (bus.cpu_addr[31:16])
      16'h0000: req_bank = BankRam;
      16'hFFFE: req_bank = BankRom;
      16'hF800: req_bank = BankNvram;
      default:  req_bank = BankNone;
    endcase
  end

  // Ready/data of the selected slave only; the others are ignored.
  always_comb begin
    sel_rdy  = 1'b0;
    sel_data = '0;
    unique case (bank_q)
      BankRam: begin
        sel_rdy  = bus.ram_rdy;
        sel_data = bus.ram_data_out;
      end
      BankRom: begin
        sel_rdy  = bus.rom_rdy;
        sel_data = bus.rom_data_out;
      end
      BankNvram: begin
        sel_rdy  = bus.nvram_rdy;
        sel_data = bus.nvram_data_out;
      end
      default: begin
        sel_rdy  = 1'b0;
        sel_data = '0;
      end
    endcase
  end

  // Next-state and request latching.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef LIMN2600_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          bank_d  = req_bank;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          if (req_bank == BankNone || (req_bank == BankRom && bus.cpu_we)) begin
            state_d = StErr;
            rdata_d = '0;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef LIMN2600_BUS_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StWait: begin
        if (sel_rdy) begin
          // Writes return zero; the slave's data bus is meaningless then.
          rdata_d = we_q ? '0 : sel_data;
          state_d = StResp;
        end
`ifdef LIMN2600_BUS_TIMEOUT_EN
        else if (cnt_q == TimeoutCnt) begin
          rdata_d = '0;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
`endif
      end
      StResp:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      bank_q  <= BankNone;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef LIMN2600_BUS_TIMEOUT_EN
  // Wait-cycle counter for the rdy timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Outputs decoded from state; the slave strobe lives only in ISSUE.
  always_comb begin
    issue           = (state_q == StIssue);
    bus.cpu_busy    = (state_q != StIdle);
    bus.cpu_ack     = (state_q == StResp);
    bus.cpu_err     = (state_q == StErr);
    bus.cpu_rdata   = rdata_q;
    bus.mem_addr    = addr_q;
    bus.mem_data_in = wdata_q;
    bus.mem_we      = issue & we_q;
    bus.mem_oe      = issue & ~we_q;
    bus.rom_ce      = issue & (bank_q == BankRom);
    bus.ram_ce      = issue & (bank_q == BankRam);
    bus.nvram_ce    = issue & (bank_q == BankNvram);
  end

  // Structural invariants of the bus protocol.
  a_ce_onehot: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({bus.rom_ce, bus.ram_ce, bus.nvram_ce}));
  a_ack_err_excl: assert property (@(posedge clk) disable iff (!rst)
    !(bus.cpu_ack && bus.cpu_err));
  a_dir_with_ce: assert property (@(posedge clk) disable iff (!rst)
    (bus.mem_we || bus.mem_oe) |-> (bus.rom_ce || bus.ram_ce || bus.nvram_ce));

endmodule

// File: tb/tb_limn2600_bus_ctrl.sv
// Bench for limn2600_bus_ctrl: directed scenarios followed by random
// transactions, checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_limn2600_bus_ctrl;
  localparam int unsigned DW = 32;
`ifdef LIMN2600_BUS_TIMEOUT_EN
  localparam int unsigned TO         = 8;
  localparam bit          TIMEOUT_ON = 1'b1;
`else
  localparam int unsigned TO         = 255;
  localparam bit          TIMEOUT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  limn2600_bus_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  limn2600_bus_ctrl #(
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests  = 0;
  int failed = 0;

  // ---------------- slave model (ROM image, RAM/NVRAM storage) ----------------
  int            lat_cfg = 0;
  bit            stray_rom = 1'b0;
  logic [2:0]    sl_rdy;
  logic [DW-1:0] sl_data;
  logic          sl_pend;
  int            sl_cnt;
  logic [1:0]    sl_bank;
  logic [7:0]    sl_idx;
  logic [31:0]   sl_addr;
  logic [DW-1:0] slv_mem [0:255];
  logic          ce_any;
  logic [1:0]    ce_bank;
  logic [7:0]    ce_idx;

  assign ce_any  = bus.rom_ce | bus.ram_ce | bus.nvram_ce;
  assign ce_bank = bus.ram_ce ? 2'd1 : (bus.nvram_ce ? 2'd2 : 2'd0);
  assign ce_idx  = {ce_bank, bus.mem_addr[7:2]};

  assign bus.rom_rdy        = sl_rdy[0] | stray_rom;
  assign bus.ram_rdy        = sl_rdy[1];
  assign bus.nvram_rdy      = sl_rdy[2];
  assign bus.rom_data_out   = sl_rdy[0] ? sl_data : 32'hA0A0_0001;
  assign bus.ram_data_out   = sl_rdy[1] ? sl_data : 32'hA0A0_0002;
  assign bus.nvram_data_out = sl_rdy[2] ? sl_data : 32'hA0A0_0003;

  function automatic logic [31:0] rom_image(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [DW-1:0] slave_read(input logic [1:0] b, input logic [7:0] idx,
                                               input logic [31:0] a);
    logic [DW-1:0] v;
    if (b == 2'd0) return rom_image(a);
    v = slv_mem[idx];
    if ($isunknown(v)) return '0;
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sl_rdy  <= '0;
      sl_data <= '0;
      sl_pend <= 1'b0;
      sl_cnt  <= 0;
      sl_bank <= '0;
      sl_idx  <= '0;
      sl_addr <= '0;
    end else begin
      sl_rdy <= '0;
      if (ce_any) begin
        sl_bank <= ce_bank;
        sl_idx  <= ce_idx;
        sl_addr <= bus.mem_addr;
        if (bus.mem_we) slv_mem[ce_idx] <= bus.mem_data_in;
        if (lat_cfg == 0) begin
          sl_rdy[ce_bank] <= 1'b1;
          sl_data <= bus.mem_we ? 32'hFEED_F00D : slave_read(ce_bank, ce_idx, bus.mem_addr);
          sl_pend <= 1'b0;
        end else begin
          sl_pend <= 1'b1;
          sl_cnt  <= lat_cfg;
        end
      end else if (sl_pend) begin
        if (sl_cnt == 1) begin
          sl_rdy[sl_bank] <= 1'b1;
          sl_data <= slave_read(sl_bank, sl_idx, sl_addr);
          sl_pend <= 1'b0;
        end
        sl_cnt <= sl_cnt - 1;
      end
    end
  end

  // ---------------- reference model (transaction level) ----------------
  logic [DW-1:0] ref_mem [bit [31:0]];

  // Outcome of one request: error or ack, response cycle after accept, data,
  // and which ce ({nvram, ram, rom}) should pulse.
  function automatic void ref_txn(input logic we, input logic [31:0] addr,
                                  input logic [DW-1:0] wdata, input int lat,
                                  output bit err, output logic [DW-1:0] rdata,
                                  output int cyc, output logic [2:0] ce);
    int        b;
    bit [31:0] k;
    case (addr[31:16])
      16'h0000: b = 1;
      16'hFFFE: b = 0;
      16'hF800: b = 2;
      default:  b = -1;
    endcase
    err   = (b < 0) || (b == 0 && we);
    rdata = '0;
    cyc   = 1;
    ce    = '0;
    if (err) return;
    ce  = 3'b001 << b;
    k   = {b[1:0], addr[31:2]};
    cyc = 3 + lat;
    if (TIMEOUT_ON && lat > int'(TO)) begin
      err = 1'b1;
      cyc = 3 + int'(TO);
      return;
    end
    if (we) ref_mem[k] = wdata;
    else if (b == 0) rdata = rom_image(addr);
    else if (ref_mem.exists(k)) rdata = ref_mem[k];
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 64'({bus.cpu_busy, bus.cpu_ack, bus.cpu_err, bus.mem_we, bus.mem_oe,
                            bus.rom_ce, bus.ram_ce, bus.nvram_ce}), 64'd0);
    chk({tag, "_rdata"}, 64'(bus.cpu_rdata), 64'd0);
    chk({tag, "_maddr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_mdata"}, 64'(bus.mem_data_in), 64'd0);
  endtask

  // One request from accept to the cycle after its response.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [DW-1:0] wdata,
                        input int lat, input bit extra, input string tag);
    bit            exp_err;
    logic [DW-1:0] exp_rdata;
    int            exp_cyc;
    logic [2:0]    exp_ce;
    int            cyc;
    bit            done;
    logic          got_ack;
    logic          got_err;
    logic          busy_at_resp;
    logic [DW-1:0] got_rdata;
    int            resp_cyc;
    int            ce_cnt;
    bit            ce_bad;
    int            late;
    ref_txn(we, addr, wdata, lat, exp_err, exp_rdata, exp_cyc, exp_ce);
    lat_cfg      = lat;
    done         = 1'b0;
    got_ack      = 1'b0;
    got_err      = 1'b0;
    busy_at_resp = 1'b0;
    got_rdata    = 'x;
    resp_cyc     = -1;
    ce_cnt       = 0;
    ce_bad       = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, 64'(bus.cpu_busy), 64'd0);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(negedge clk);
    // Unqualified request fields are scrambled to expose missing latches.
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'($urandom);
    bus.cpu_addr  = $urandom;
    bus.cpu_wdata = $urandom;
    cyc = 1;
    while (!done && cyc <= exp_cyc + 4) begin
      if (ce_any) begin
        ce_cnt++;
        if ({bus.nvram_ce, bus.ram_ce, bus.rom_ce} !== exp_ce || bus.mem_we !== we ||
            bus.mem_oe !== !we || bus.mem_addr !== addr || bus.mem_data_in !== wdata || cyc != 1)
          ce_bad = 1'b1;
      end else if (bus.mem_we !== 1'b0 || bus.mem_oe !== 1'b0) begin
        ce_bad = 1'b1;
      end
      if (bus.cpu_ack || bus.cpu_err) begin
        done         = 1'b1;
        got_ack      = bus.cpu_ack;
        got_err      = bus.cpu_err;
        got_rdata    = bus.cpu_rdata;
        busy_at_resp = bus.cpu_busy;
        resp_cyc     = cyc;
      end
      if (extra && cyc == 2) begin
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h0000_0020;
      end
      if (extra && cyc == 3) begin
        bus.cpu_req = 1'b0;
        stray_rom   = 1'b1;
      end
      if (extra && cyc == 4) stray_rom = 1'b0;
      @(negedge clk);
      cyc++;
    end
    stray_rom = 1'b0;
    chk({tag, "_kind"}, 64'({got_ack, got_err}), exp_err ? 64'd1 : 64'd2);
    chk({tag, "_cycle"}, 64'(resp_cyc), 64'(exp_cyc));
    chk({tag, "_rdata"}, 64'(got_rdata), 64'(exp_rdata));
    chk({tag, "_busy_resp"}, 64'(busy_at_resp), 64'd1);
    chk({tag, "_ce_count"}, 64'(ce_cnt), exp_err && !(TIMEOUT_ON && lat > int'(TO)) ? 64'd0 : 64'd1);
    chk({tag, "_ce_ok"}, 64'(ce_bad), 64'd0);
    chk({tag, "_after"}, 64'({bus.cpu_busy, bus.cpu_ack, bus.cpu_err}), 64'd0);
    chk({tag, "_held"}, 64'(bus.cpu_rdata), 64'(exp_rdata));
    if (extra) begin
      late = 0;
      repeat (6) begin
        if (bus.cpu_ack || bus.cpu_err || bus.cpu_busy) late++;
        @(negedge clk);
      end
      chk({tag, "_dropped"}, 64'(late), 64'd0);
    end
  endtask

  // Global guard so the run always ends.
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1);
  end

  initial begin
    int          sel;
    logic [15:0] hi;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          lat;
    int          stale;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;

    // Reset state.
    #1 rst = 1'b0;
    #2 chk_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("post_reset");

    // RAM write then read of 0xDEADBEEF.
    do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0, "ram_wr");
    do_txn(1'b0, 32'h0000_0010, 32'h1111_2222, 0, 1'b0, "ram_rd");

    // NVRAM write and readback with latency.
    do_txn(1'b1, 32'hF800_0004, 32'h1234_5678, 1, 1'b0, "nv_wr");
    do_txn(1'b0, 32'hF800_0004, 32'h0, 2, 1'b0, "nv_rd");
    do_txn(1'b1, 32'hF800_0040, 32'h0000_0041, 0, 1'b0, "nv_ser");

    // Decode errors: ROM write, unmapped read.
    do_txn(1'b1, 32'hFFFE_0000, 32'hCAFE_CAFE, 0, 1'b0, "rom_wr");
    do_txn(1'b0, 32'h4000_0000, 32'h0, 0, 1'b0, "unmapped");

    // ROM read.
    do_txn(1'b0, 32'hFFFE_0010, 32'h0, 0, 1'b0, "rom_rd");

    // Slow RAM, stray ROM ready, request while busy.
    do_txn(1'b0, 32'h0000_0010, 32'h0, 5, 1'b1, "slow_ram");

`ifdef LIMN2600_BUS_TIMEOUT_EN
    do_txn(1'b0, 32'h0000_0008, 32'h0, 1000, 1'b0, "timeout");
    do_txn(1'b0, 32'h0000_0010, 32'h0, int'(TO), 1'b0, "to_edge");
`endif

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 4) hi = 16'h0000;
      else if (sel < 7) hi = 16'hF800;
      else if (sel < 9) hi = 16'hFFFE;
      else begin
        hi = 16'($urandom);
        if (hi == 16'h0000 || hi == 16'hFFFE || hi == 16'hF800) hi = 16'h1234;
      end
      addr  = {hi, 8'h00, 6'($urandom_range(0, 15)), 2'($urandom)};
      we    = 1'($urandom);
      wdata = $urandom;
      lat   = int'($urandom_range(0, 3));
      do_txn(we, addr, wdata, lat, 1'b0, "rand");
    end

    // Reset during WAIT abandons the request.
    lat_cfg = 20;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0000_0014;
    bus.cpu_wdata = 32'h7777_7777;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 64'(bus.cpu_busy), 64'd1);
    #2 rst = 1'b0;
    #1 chk_zero("mid_reset");
    @(negedge clk);
    rst   = 1'b1;
    stale = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.cpu_ack || bus.cpu_err || bus.cpu_busy) stale++;
    end
    chk("no_stale", 64'(stale), 64'd0);
    do_txn(1'b0, 32'h0000_0010, 32'h0, 1, 1'b0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
